// File: rtl/smul_share_arb_if.sv
// smul_share_arb_if: request/grant/result bundle between two requesters and the shared multiplier
interface smul_share_arb_if #(parameter int DATAWIDTH = 64);
  logic req0, req1, gnt0, gnt1, done0, done1, busy;
  logic [DATAWIDTH-1:0] a0, b0, a1, b1, prod;
  modport master (output req0, a0, b0, req1, a1, b1, input gnt0, gnt1, done0, done1, prod, busy);
  modport slave (input req0, a0, b0, req1, a1, b1, output gnt0, gnt1, done0, done1, prod, busy);
endinterface

// File: rtl/smul_share_arb.sv
// smul_share_arb: one signed multiplier shared round-robin between two requesters
module smul_share_arb #(
  parameter int DATAWIDTH  = 64,
  parameter int MUL_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  smul_share_arb_if.slave      bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] count;
  logic [DATAWIDTH-1:0] a_r, b_r;
  logic idx, last, win, any_req, start, fin;
  logic signed [DATAWIDTH-1:0] mul;
  assign any_req = bus.req0 | bus.req1;
  // on a tie the requester not served last wins
  assign win = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign start = (state == IDLE) & any_req;
  assign fin = (state == CALC) & (count == 4'd0);
  assign mul = $signed(a_r) * $signed(b_r);
  assign bus.busy = (state != IDLE);
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (any_req ? CALC : IDLE) :
               (state == CALC) ? (count == 4'd0 ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      a_r <= '0;
      b_r <= '0;
      idx <= 1'b0;
      last <= 1'b1;
      count <= 4'd0;
      bus.prod <= '0;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
    end else begin
      bus.gnt0 <= start & ~win;
      bus.gnt1 <= start & win;
      bus.done0 <= fin & ~idx;
      bus.done1 <= fin & idx;
      if (start) begin
        a_r <= win ? bus.a1 : bus.a0;
        b_r <= win ? bus.b1 : bus.b0;
        idx <= win;
        count <= 4'(MUL_CYCLES - 1);
      end else if (state == CALC) begin
        if (count != 4'd0) count <= count - 4'd1;
        else bus.prod <= mul;
      end
      if (state == DONE) last <= idx;
    end
endmodule
